// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among N_REQ requesters,
// with lock for atomic RMW. Define ARB_ADDR_CHECK_EN to reject addr >= RAM_SIZE.
module ram_port_arbiter #(
  parameter int N_REQ    = 2,
  parameter int RAM_SIZE = 1024,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [N_REQ-1:0]          err,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wr_data,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_rd_data
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  if (N_REQ < 2 || N_REQ > 8 || RAM_SIZE < 1) begin : g_bad_cfg
    $error("ram_port_arbiter: bad parameters");
  end

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [IW-1:0]     win, idx;
  logic              hit, acc, bad;
  logic [ADDR_W-1:0] win_addr;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    hit = 1'b0;
    win = rr_ptr_q;
    idx = '0;
    if (state_q == LOCKED) begin
      win = owner_q;
      hit = req[owner_q];
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = IW'((int'(rr_ptr_q) + i) % N_REQ);
        if (!hit && req[idx]) begin
          hit = 1'b1;
          win = idx;
        end
      end
    end
  end

  assign win_addr = req_addr[win*ADDR_W +: ADDR_W];

`ifdef ARB_ADDR_CHECK_EN
  assign bad = win_addr >= ADDR_W'(RAM_SIZE);
`else
  assign bad = 1'b0;
`endif

  assign acc         = rst_n & hit;
  assign gnt         = acc ? (N_REQ'(1) << win) : '0;
  assign ram_we      = acc & req_we[win] & ~bad;
  assign ram_addr    = (acc & ~bad) ? win_addr : '0;
  assign ram_wr_data = req_wdata[win*DATA_W +: DATA_W];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          rr_ptr_d = inc(win);
          if (req_lock[win]) begin
            state_d = LOCKED;
            owner_d = win;
          end
        end
      end
      LOCKED: begin
        // lock dropped: either the final access is granted now or owner went idle
        if (!req_lock[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      rvalid_q <= gnt & {N_REQ{~req_we[win] & ~bad}};
      if (|rvalid_q) rdata_q <= ram_rd_data;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = (|rvalid_q) ? ram_rd_data : rdata_q;

`ifdef ARB_ADDR_CHECK_EN
  logic [N_REQ-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= gnt & {N_REQ{bad}};
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural write-first RAM.
// Covers round-robin, lock, reset mid-read and the address range check.
module tb_ram_port_arbiter;

`ifdef ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req_we, req_lock;
  logic [31:0] a0, a1, d0, d1;
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata, ram_addr, ram_wr_data, ram_rd_data;
  logic        ram_we;

  logic [31:0] mem [1024];

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .N_REQ(2), .RAM_SIZE(1024), .ADDR_W(32), .DATA_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr({a1, a0}), .req_wdata({d1, d0}),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_we(ram_we), .ram_rd_data(ram_rd_data)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:0]] <= ram_wr_data;
    ram_rd_data <= ram_we ? ram_wr_data : mem[ram_addr[9:0]];
  end

  typedef struct {
    logic [1:0]  req, we, lk;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  g, rv;
    logic [31:0] rd;
  } vec_t;

  vec_t v[21];

  function automatic vec_t mk(
    input logic [1:0] rq, input logic [1:0] w, input logic [1:0] l,
    input logic [31:0] x0, input logic [31:0] x1,
    input logic [31:0] y0, input logic [31:0] y1,
    input logic [1:0] g, input logic [1:0] rv, input logic [31:0] rd);
    vec_t t;
    t.req = rq; t.we = w; t.lk = l;
    t.a0 = x0; t.a1 = x1; t.d0 = y0; t.d1 = y1;
    t.g = g; t.rv = rv; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s[%0d]: got %h want %h", nm, i, act, exp);
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] w,
                       input logic [1:0] l,
                       input logic [31:0] x0, input logic [31:0] x1,
                       input logic [31:0] y0, input logic [31:0] y1);
    @(negedge clk);
    req = rq; req_we = w; req_lock = l;
    a0 = x0; a1 = x1; d0 = y0; d1 = y1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; req_we = '0; req_lock = '0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    #1;
    chk("rst_gnt", 0, 32'(gnt), 0);
    chk("rst_rvalid", 0, 32'(rvalid), 0);
    chk("rst_rdata", 0, rdata, 0);
    chk("rst_err", 0, 32'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    v[0]  = mk(2'b01, 2'b01, 2'b00, 5, 0, 32'hDEADBEEF, 0,
               2'b01, 2'b00, 0);
    v[1]  = mk(2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 2'b01, 2'b00, 0);
    v[2]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0,
               2'b00, 2'b01, 32'hDEADBEEF);
    v[3]  = mk(2'b01, 2'b01, 2'b00, 1, 0, 32'h11, 0,
               2'b01, 2'b00, 32'hDEADBEEF);
    v[4]  = mk(2'b10, 2'b10, 2'b00, 0, 2, 0, 32'h22,
               2'b10, 2'b00, 32'hDEADBEEF);
    v[5]  = mk(2'b11, 2'b00, 2'b00, 1, 2, 0, 0,
               2'b01, 2'b00, 32'hDEADBEEF);
    v[6]  = mk(2'b11, 2'b00, 2'b00, 1, 2, 0, 0, 2'b10, 2'b01, 32'h11);
    v[7]  = mk(2'b11, 2'b00, 2'b00, 1, 2, 0, 0, 2'b01, 2'b10, 32'h22);
    v[8]  = mk(2'b11, 2'b00, 2'b00, 1, 2, 0, 0, 2'b10, 2'b01, 32'h11);
    v[9]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 32'h22);
    v[10] = mk(2'b01, 2'b01, 2'b00, 8, 0, 32'h7, 0,
               2'b01, 2'b00, 32'h22);
    v[11] = mk(2'b11, 2'b00, 2'b10, 1, 8, 0, 0, 2'b10, 2'b00, 32'h22);
    v[12] = mk(2'b11, 2'b10, 2'b00, 1, 8, 0, 32'h8,
               2'b10, 2'b10, 32'h7);
    v[13] = mk(2'b01, 2'b00, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 32'h7);
    v[14] = mk(2'b10, 2'b00, 2'b00, 0, 8, 0, 0, 2'b10, 2'b01, 32'h11);
    v[15] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 32'h8);
    v[16] = mk(2'b10, 2'b00, 2'b10, 0, 2, 0, 0, 2'b10, 2'b00, 32'h8);
    v[17] = mk(2'b11, 2'b00, 2'b10, 5, 2, 0, 0, 2'b10, 2'b10, 32'h22);
    v[18] = mk(2'b10, 2'b00, 2'b00, 0, 2, 0, 0, 2'b10, 2'b10, 32'h22);
    v[19] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 32'h22);
    v[20] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 32'h22);

    for (int i = 0; i < 21; i++) begin
      drive(v[i].req, v[i].we, v[i].lk, v[i].a0, v[i].a1,
            v[i].d0, v[i].d1);
      chk("gnt", i, 32'(gnt), 32'(v[i].g));
      chk("rvalid", i, 32'(rvalid), 32'(v[i].rv));
      chk("rdata", i, rdata, v[i].rd);
      chk("err", i, 32'(err), 0);
    end

    // reset right after a read grant
    drive(2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
    chk("pre_rst_gnt", 0, 32'(gnt), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_we = 2'b01; a0 = 7; d0 = 32'h99;
    #1;
    chk("in_rst_gnt", 0, 32'(gnt), 0);
    chk("in_rst_we", 0, 32'(ram_we), 0);
    chk("in_rst_addr", 0, ram_addr, 0);
    chk("in_rst_rvalid", 0, 32'(rvalid), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = '0; req_we = '0;
    #1;
    chk("rel_rvalid", 0, 32'(rvalid), 0);
    chk("rel_rdata", 0, rdata, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("post_rvalid", 0, 32'(rvalid), 0);
    drive(2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
    chk("rr_after_rst", 0, 32'(gnt), 1);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("rr_rvalid", 0, 32'(rvalid), 1);
    chk("rr_rdata", 0, rdata, 32'h11);

    // out-of-range address
    drive(2'b01, 2'b01, 2'b00, 0, 0, 32'hA0, 0);
    chk("oor_pre_gnt", 0, 32'(gnt), 1);
    drive(2'b01, 2'b01, 2'b00, 1024, 0, 32'h55, 0);
    chk("oor_gnt", 0, 32'(gnt), 1);
    chk("oor_we", 0, 32'(ram_we), CHK ? 0 : 1);
    chk("oor_addr", 0, ram_addr, CHK ? 0 : 1024);
    drive(2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("oor_err", 0, 32'(err), CHK ? 1 : 0);
    chk("oor_rvalid", 0, 32'(rvalid), 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("oor_rd_valid", 0, 32'(rvalid), 1);
    chk("oor_rd_data", 0, rdata, CHK ? 32'hA0 : 32'h55);
    chk("oor_err_clr", 0, 32'(err), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
